// File: rtl/mmio_spi_pkg.sv
// Shared register map, chip-select modes and controller states for mmio_spi_master.
package mmio_spi_pkg;

  localparam logic [7:0] ADDR_SCKDIV = 8'h00;
  localparam logic [7:0] ADDR_CSMODE = 8'h18;
  localparam logic [7:0] ADDR_TXDATA = 8'h48;
  localparam logic [7:0] ADDR_RXDATA = 8'h4C;

  typedef enum logic [1:0] {
    CS_AUTO = 2'd0,
    CS_HOLD = 2'd2,
    CS_OFF  = 2'd3
  } csmode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop in the same cycle frees room for a push even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Accept pop when data exists; accept push when space exists or is being freed.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_spi_master.sv
// Memory-mapped SPI master (CPOL=0, MSB first) with TX/RX byte FIFOs.
module mmio_spi_master
  import mmio_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 12,
  parameter int unsigned RESET_DIV  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rq_en,
  input  logic [7:0]  rq_addr,
  input  logic        rq_write,
  input  logic [31:0] rq_wdata,
  output logic        rs_en,
  output logic [31:0] rs_data,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] sckdiv_q, sckdiv_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       csmode_q, csmode_d;
  logic [3:0]       bit_edge_q, bit_edge_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             sck_q, sck_d;
  logic             cs_n_q, cs_n_d;
  logic             rs_en_q;
  logic [31:0]      rs_data_q, rs_data_d;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       tx_rdata, rx_rdata;
  logic             tick, start;
  logic             unused_wdata;

  assign unused_wdata = ^{rq_wdata, rx_full};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_data(rq_wdata[7:0]),
    .pop(tx_pop), .pop_data(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_sh_q),
    .pop(rx_pop), .pop_data(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  // CSMODE decisions use the value being written this cycle so cs_n reacts on the same edge.
  assign tick  = (cnt_q == div_q);
  assign start = !tx_empty && (csmode_d != CS_OFF);

  // Register file: writes, read mux, FIFO strobes from the bus.
  always_comb begin
    sckdiv_d  = sckdiv_q;
    csmode_d  = csmode_q;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    rs_data_d = '0;
    if (rq_en && rq_write) begin
      case (rq_addr)
        ADDR_SCKDIV: sckdiv_d = rq_wdata[DIV_W-1:0];
        ADDR_CSMODE: csmode_d = rq_wdata[1:0];
        ADDR_TXDATA: tx_push  = 1'b1;
        default: ;
      endcase
    end else if (rq_en) begin
      case (rq_addr)
        ADDR_SCKDIV: rs_data_d = 32'(sckdiv_q);
        ADDR_CSMODE: rs_data_d = {30'b0, csmode_q};
        ADDR_TXDATA: rs_data_d = {tx_full, 31'b0};
        ADDR_RXDATA: begin
          if (rx_empty) begin
            rs_data_d = 32'h8000_0000;
          end else begin
            rs_data_d = {24'b0, rx_rdata};
            rx_pop    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Serial engine: next state, half-period timing, shifting and chip select.
  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    div_d      = div_q;
    bit_edge_d = bit_edge_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_pop  = 1'b1;
          tx_sh_d = tx_rdata;
          div_d   = sckdiv_q;
          cs_n_d  = 1'b0;
          state_d = ST_SETUP;
        end else if (csmode_d != CS_HOLD) begin
          cs_n_d = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          bit_edge_d = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          bit_edge_d = bit_edge_q + 1'b1;
          // Received bits go to a separate shifter so the outgoing LSB is not overwritten early.
          if (!bit_edge_q[0]) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], spi_miso};
          end else begin
            sck_d   = 1'b0;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (bit_edge_q == 4'd15) begin
            rx_push = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (start) begin
            tx_pop  = 1'b1;
            tx_sh_d = tx_rdata;
            div_d   = sckdiv_q;
            cnt_d   = '0;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
            if (csmode_d != CS_HOLD) cs_n_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and register flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sckdiv_q   <= DIV_W'(RESET_DIV);
      csmode_q   <= CS_AUTO;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_edge_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      rs_en_q    <= 1'b0;
      rs_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sckdiv_q   <= sckdiv_d;
      csmode_q   <= csmode_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_edge_q <= bit_edge_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      rs_en_q    <= rq_en;
      rs_data_q  <= rs_data_d;
    end
  end

  assign rs_en    = rs_en_q;
  assign rs_data  = rs_data_q;
  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = (state_q != ST_IDLE) ? tx_sh_q[7] : 1'b0;

endmodule

// File: tb/tb_mmio_spi_master.sv
// Directed bench for mmio_spi_master with MOSI looped back to MISO.
module tb_mmio_spi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq_en, rq_write;
  logic [7:0]  rq_addr;
  logic [31:0] rq_wdata;
  logic        rs_en;
  logic [31:0] rs_data;
  logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;

  int n_vec     = 0;
  int n_miscmp  = 0;
  int toggles;
  int low_cyc;
  int rises;

  always #5 clk = ~clk;

  assign spi_miso = spi_mosi;

  mmio_spi_master #(.FIFO_DEPTH(4), .DIV_W(12), .RESET_DIV(3)) dut (
    .clk(clk), .reset(reset),
    .rq_en(rq_en), .rq_addr(rq_addr), .rq_write(rq_write), .rq_wdata(rq_wdata),
    .rs_en(rs_en), .rs_data(rs_data),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    rq_en = 1'b1; rq_write = w; rq_addr = a; rq_wdata = d;
  endtask

  task automatic release_bus();
    @(negedge clk);
    rq_en = 1'b0; rq_write = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    drive(a, 1'b1, d);
    release_bus();
    check("wr_rs_en", {31'b0, rs_en}, 32'd1);
    check("wr_rs_data", rs_data, 32'd0);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    drive(a, 1'b0, 32'd0);
    release_bus();
    check({tag, "_rs_en"}, {31'b0, rs_en}, 32'd1);
    check(tag, rs_data, exp);
  endtask

  // Watch one cs_n-low window: count sck toggles and low cycles until cs_n returns high.
  task automatic wait_frame(input int max_cyc, output int tg, output int lo);
    int  cyc  = 0;
    bit  seen = 1'b0;
    bit  done = 1'b0;
    logic prev = spi_sck;
    tg = 0; lo = 0;
    while (!done && cyc < max_cyc) begin
      if (spi_sck !== prev) begin
        tg++;
        if (spi_cs_n !== 1'b0) check("sck_with_cs_high", {31'b0, spi_cs_n}, 32'd0);
      end
      prev = spi_sck;
      if (spi_cs_n === 1'b0) begin
        seen = 1'b1;
        lo++;
      end else if (seen) begin
        done = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("frame_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rq_en = 1'b0; rq_write = 1'b0; rq_addr = '0; rq_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_sck",  {31'b0, spi_sck},  32'd0);
    check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    check("rst_rs_en", {31'b0, rs_en},   32'd0);
    check("rst_rs_data", rs_data,        32'd0);
    reset = 1'b0;

    bus_read(8'h00, 32'd3, "sckdiv_rst");
    bus_read(8'h18, 32'd0, "csmode_rst");
    bus_read(8'h48, 32'd0, "txdata_rst");
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_rst");
    bus_write(8'h04, 32'hFFFF_FFFF);
    bus_read(8'h04, 32'd0, "unmapped_rd");
    @(negedge clk);
    check("rs_en_idle", {31'b0, rs_en}, 32'd0);

    // Loopback 0xA5 at clk/2: 1+16+1 half-periods of one cycle each.
    bus_write(8'h00, 32'd0);
    bus_read(8'h00, 32'd0, "sckdiv_rb0");
    bus_write(8'h48, 32'hA5);
    wait_frame(200, toggles, low_cyc);
    check("a5_toggles", toggles, 32'd16);
    check("a5_cs_low", low_cyc, 32'd18);
    check("mosi_idle", {31'b0, spi_mosi}, 32'd0);
    bus_read(8'h4C, 32'h0000_00A5, "rx_a5");
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_a5");

    // SCKDIV=3: two bytes back-to-back, 4-cycle half-periods, cs_n low throughout.
    bus_write(8'h00, 32'd3);
    drive(8'h48, 1'b1, 32'h3C);
    drive(8'h48, 1'b1, 32'hC3);
    release_bus();
    wait_frame(1000, toggles, low_cyc);
    check("2b_toggles", toggles, 32'd32);
    check("2b_cs_low", low_cyc, 32'd144);
    bus_read(8'h4C, 32'h0000_003C, "rx_3c");
    bus_read(8'h4C, 32'h0000_00C3, "rx_c3");
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_2b");

    // Six TX writes in consecutive cycles: one popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) drive(8'h48, 1'b1, 32'h10 + i);
    drive(8'h48, 1'b0, 32'd0);
    release_bus();
    check("tx_full_rd", rs_data, 32'h8000_0000);
    wait_frame(3000, toggles, low_cyc);
    check("burst_toggles", toggles, 32'd80);
    bus_read(8'h48, 32'd0, "tx_not_full");
    for (int i = 0; i < 4; i++) bus_read(8'h4C, 32'h10 + i, "rx_burst");
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_burst");

    // RX overflow: six bytes, only the first four kept.
    bus_write(8'h00, 32'd0);
    for (int i = 1; i <= 3; i++) drive(8'h48, 1'b1, i);
    release_bus();
    wait_frame(500, toggles, low_cyc);
    check("ovf1_toggles", toggles, 32'd48);
    for (int i = 4; i <= 6; i++) drive(8'h48, 1'b1, i);
    release_bus();
    wait_frame(500, toggles, low_cyc);
    check("ovf2_toggles", toggles, 32'd48);
    for (int i = 1; i <= 4; i++) bus_read(8'h4C, i, "rx_ovf");
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_ovf");

    // CSMODE=HOLD keeps cs_n low after the byte; AUTO releases it on the write edge.
    bus_write(8'h18, 32'd2);
    bus_read(8'h18, 32'd2, "csmode_rb2");
    bus_write(8'h48, 32'h55);
    repeat (40) @(negedge clk);
    check("hold_cs_n", {31'b0, spi_cs_n}, 32'd0);
    check("hold_sck", {31'b0, spi_sck}, 32'd0);
    check("hold_mosi", {31'b0, spi_mosi}, 32'd0);
    bus_read(8'h4C, 32'h55, "rx_55");
    bus_write(8'h18, 32'd0);
    check("auto_cs_n", {31'b0, spi_cs_n}, 32'd1);

    // CSMODE=OFF inhibits transmission until re-enabled.
    bus_write(8'h18, 32'd3);
    bus_write(8'h48, 32'h77);
    repeat (30) @(negedge clk);
    check("off_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("off_sck", {31'b0, spi_sck}, 32'd0);
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_off");
    bus_write(8'h18, 32'd0);
    wait_frame(200, toggles, low_cyc);
    check("off_resume_toggles", toggles, 32'd16);
    bus_read(8'h4C, 32'h77, "rx_77");

    // Reset in the middle of 0xFF aborts immediately and restores defaults.
    bus_write(8'h00, 32'd5);
    bus_write(8'h48, 32'hFF);
    rises = 0;
    for (int c = 0; c < 500 && rises < 4; c++) begin
      logic prev_sck = spi_sck;
      @(negedge clk);
      if (!prev_sck && spi_sck) rises++;
    end
    check("mid_byte_reached", rises, 32'd4);
    reset = 1'b1;
    #1;
    check("abort_sck", {31'b0, spi_sck}, 32'd0);
    check("abort_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("abort_mosi", {31'b0, spi_mosi}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(8'h4C, 32'h8000_0000, "rx_empty_abort");
    bus_read(8'h00, 32'd3, "sckdiv_abort");
    bus_read(8'h18, 32'd0, "csmode_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
